// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Contents: opcode constants, shared-bus source select codes and the
// sequencer state encoding used by instr_sequencer.
package instr_sequencer_pkg;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1000;
    localparam logic [3:0] OP_LDI = 4'b1010;

    // Bus source select codes; 0..3 select reg[n] directly
    localparam logic [2:0] SEL_IMM  = 3'd4;
    localparam logic [2:0] SEL_G    = 3'd5;
    localparam logic [2:0] SEL_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Small instruction queue (synchronous FIFO, no bypass).
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   push, din      write din when push and not full
//   pop            drop the head entry when pop and not empty
//   dout           head entry (combinational read of the head slot)
//   full, empty    occupancy flags
// Simultaneous push and pop keep the count unchanged. DEPTH must be a
// power of two so the pointers wrap naturally.
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: contents are only read when count says valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 16-bit register/ALU/bus datapath.
// Instruction words enter through a valid/ready port into a DEPTH-entry
// queue; each one is decoded into one micro-step per clock.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   iin, iin_valid   instruction word and its valid qualifier
//   iin_ready        queue can accept a word
//   reg_in           one-hot register write enable (bus -> reg)
//   bus_sel          0..3 reg[n], 4 immediate, 5 G, 7 nothing
//   imm              zero-extended immediate, nonzero only when bus_sel==4
//   a_in, g_in       load ALU A from bus / load G with A op bus
//   alu_sub          0 add, 1 subtract (with g_in)
//   out_en           capture bus to output port
//   done, illegal    final micro-step pulse; illegal marks an unknown opcode
//   busy             sequencer not in IDLE
//   state_dbg        current FSM state
// Handshake: a word transfers on a rising edge where iin_valid and
// iin_ready are both high; iin_ready depends only on queue occupancy.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] iin,
    input  logic             iin_valid,
    output logic             iin_ready,
    output logic [NREG-1:0]  reg_in,
    output logic [2:0]       bus_sel,
    output logic [WIDTH-1:0] imm,
    output logic             a_in,
    output logic             g_in,
    output logic             alu_sub,
    output logic             out_en,
    output logic             done,
    output logic             illegal,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    seq_state_t       state, state_next;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             last_step;

    logic [3:0] op;
    logic [1:0] rx;
    logic [1:0] ry;

    assign op = ir[15:12];
    assign rx = ir[11:10];
    assign ry = ir[9:8];

    assign iin_ready = ~fifo_full;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    instr_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (iin_valid),
        .pop   (fifo_pop),
        .din   (iin),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetch from IDLE, or chain straight into the next instruction on the
    // final micro-step so back-to-back instructions have no bubble.
    assign fifo_pop = ((state == ST_IDLE) || last_step) && !fifo_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (fifo_pop) begin
                ir <= fifo_dout;
            end
        end
    end

    // Moore decode: outputs depend only on state and IR.
    always_comb begin
        state_next = state;
        last_step  = 1'b0;
        reg_in     = '0;
        bus_sel    = SEL_NONE;
        imm        = '0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        alu_sub    = 1'b0;
        out_en     = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_IDLE: begin
            end
            ST_T1: begin
                case (op)
                    OP_LDI: begin
                        bus_sel    = SEL_IMM;
                        imm        = {{(WIDTH-10){1'b0}}, ir[9:0]};
                        reg_in[rx] = 1'b1;
                        done       = 1'b1;
                        last_step  = 1'b1;
                    end
                    OP_MV: begin
                        bus_sel    = {1'b0, ry};
                        reg_in[rx] = 1'b1;
                        done       = 1'b1;
                        last_step  = 1'b1;
                    end
                    OP_OUT: begin
                        bus_sel   = {1'b0, rx};
                        out_en    = 1'b1;
                        done      = 1'b1;
                        last_step = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel    = {1'b0, rx};
                        a_in       = 1'b1;
                        state_next = ST_T2;
                    end
                    default: begin
                        done      = 1'b1;
                        illegal   = 1'b1;
                        last_step = 1'b1;
                    end
                endcase
            end
            ST_T2: begin
                bus_sel    = {1'b0, ry};
                g_in       = 1'b1;
                alu_sub    = (op == OP_SUB);
                state_next = ST_T3;
            end
            ST_T3: begin
                bus_sel    = SEL_G;
                reg_in[rx] = 1'b1;
                done       = 1'b1;
                last_step  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (fifo_pop) begin
            state_next = ST_T1;
        end else if (last_step) begin
            state_next = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed instruction words, expected
// micro-steps queued at issue time, monitor compares every busy cycle.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] iin;
    logic        iin_valid;
    logic        iin_ready;
    logic [3:0]  reg_in;
    logic [2:0]  bus_sel;
    logic [15:0] imm;
    logic        a_in, g_in, alu_sub, out_en, done, illegal, busy;
    logic [1:0]  state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    // {a_in,g_in,alu_sub,out_en,done,illegal,bus_sel,reg_in,imm}
    logic [28:0] exp_q[$];
    logic [28:0] idle_step;

    int run_len = 0;
    int last_run = 0;

    instr_sequencer #(.WIDTH(16), .NREG(4), .DEPTH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .iin       (iin),
        .iin_valid (iin_valid),
        .iin_ready (iin_ready),
        .reg_in    (reg_in),
        .bus_sel   (bus_sel),
        .imm       (imm),
        .a_in      (a_in),
        .g_in      (g_in),
        .alu_sub   (alu_sub),
        .out_en    (out_en),
        .done      (done),
        .illegal   (illegal),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    function automatic logic [28:0] st(input logic [2:0] sel, input logic [3:0] rin,
                                       input logic [15:0] im, input logic a, input logic g,
                                       input logic s, input logic o, input logic d,
                                       input logic il);
        return {a, g, s, o, d, il, sel, rin, im};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [15:0] w, output int stalls);
        stalls = 0;
        iin = w;
        iin_valid = 1'b1;
        while (!iin_ready && stalls < 100) begin
            @(negedge clock);
            stalls++;
        end
        if (!iin_ready) begin
            check("push_timeout", 32'(stalls), 32'd0);
        end
        @(negedge clock);
        iin_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clock);
        while (busy && t < 200) begin
            @(negedge clock);
            t++;
        end
        check({name, "_idle_reached"}, {31'd0, busy}, 32'd0);
        @(negedge clock);
        #1;
        check({name, "_scoreboard_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [28:0] act;
        act = {a_in, g_in, alu_sub, out_en, done, illegal, bus_sel, reg_in, imm};
        if (busy) begin
            run_len++;
            if (exp_q.size() == 0) begin
                check("unexpected_step", {3'd0, act}, {3'd0, idle_step});
            end else begin
                check("micro_step", {3'd0, act}, {3'd0, exp_q.pop_front()});
            end
        end else begin
            if (run_len > 0) begin
                last_run = run_len;
            end
            run_len = 0;
            check("idle_outputs", {3'd0, act}, {3'd0, idle_step});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        idle_step = st(3'd7, 4'b0000, 16'd0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        iin = '0;
        iin_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("in_reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_ready", {31'd0, iin_ready}, 32'd1);
        check("post_reset_bus_sel", {29'd0, bus_sel}, 32'd7);

        // ldi r0,28: one IDLE fetch cycle, then a single T1 step
        exp_q.push_back(st(3'd4, 4'b0001, 16'd28, 0, 0, 0, 0, 1, 0));
        push(16'hA01C, s);
        check("ldi_fetch_idle", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("ldi_t1_busy", {31'd0, busy}, 32'd1);
        wait_idle("ldi");
        check("ldi_run", 32'(last_run), 32'd1);

        // ldi r1,10 then sub r0,r1
        exp_q.push_back(st(3'd4, 4'b0010, 16'd10, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(st(3'd0, 4'b0000, 16'd0, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(st(3'd1, 4'b0000, 16'd0, 0, 1, 1, 0, 0, 0));
        exp_q.push_back(st(3'd5, 4'b0001, 16'd0, 0, 0, 0, 0, 1, 0));
        push(16'hA40A, s);
        push(16'h2100, s);
        wait_idle("sub");
        check("sub_run", 32'(last_run), 32'd4);

        // add r1,r0 then mv r2,r1 / out r1 / ldi r3,5 held back-to-back
        exp_q.push_back(st(3'd1, 4'b0000, 16'd0, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(st(3'd0, 4'b0000, 16'd0, 0, 1, 0, 0, 0, 0));
        exp_q.push_back(st(3'd5, 4'b0010, 16'd0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(st(3'd1, 4'b0100, 16'd0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(st(3'd1, 4'b0000, 16'd0, 0, 0, 0, 1, 1, 0));
        exp_q.push_back(st(3'd4, 4'b1000, 16'd5, 0, 0, 0, 0, 1, 0));
        push(16'h1400, s);
        push(16'h0900, s);
        check("b2b_mv_stall", 32'(s), 32'd0);
        push(16'h8400, s);
        check("b2b_out_stall", 32'(s), 32'd0);
        push(16'hAC05, s);
        check("b2b_ldi_stall_full", 32'(s), 32'd2);
        wait_idle("b2b");
        check("b2b_run_no_bubble", 32'(last_run), 32'd6);

        // out r0
        exp_q.push_back(st(3'd0, 4'b0000, 16'd0, 0, 0, 0, 1, 1, 0));
        push(16'h8000, s);
        wait_idle("out");
        check("out_run", 32'(last_run), 32'd1);

        // illegal opcode followed by ldi r2,3
        exp_q.push_back(st(3'd7, 4'b0000, 16'd0, 0, 0, 0, 0, 1, 1));
        exp_q.push_back(st(3'd4, 4'b0100, 16'd3, 0, 0, 0, 0, 1, 0));
        push(16'hF000, s);
        push(16'hA803, s);
        wait_idle("illegal");
        check("illegal_run", 32'(last_run), 32'd2);

        // add r0,r0 with ldi queued; reset during T2
        exp_q.push_back(st(3'd0, 4'b0000, 16'd0, 1, 0, 0, 0, 0, 0));
        push(16'h1000, s);
        push(16'hA001, s);
        @(posedge clock);
        #2;
        check("pre_reset_state_t2", {30'd0, state_dbg}, 32'd2);
        reset = 1'b1;
        #1;
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_bus_sel", {29'd0, bus_sel}, 32'd7);
        check("async_reset_g_in", {31'd0, g_in}, 32'd0);
        check("async_reset_ready", {31'd0, iin_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("after_reset_queue_empty", {31'd0, busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
